// File: rtl/tow_pkg.sv
// Shared state encoding, score patterns and LFSR feedback for the tug-of-war round logic.
package tow_pkg;

  typedef enum logic [2:0] {
    RELEASE,
    DARK,
    LIT,
    SCORE,
    OVER
  } state_t;

  localparam logic [6:0] SCORE_WL  = 7'b1110000;
  localparam logic [6:0] SCORE_WR  = 7'b0000111;
  localparam logic [6:0] SCORE_RST = 7'b1100011;

  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every cycle; output is the registered state.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  import tow_pkg::*;

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: random dark delay, lit window, push arbitration into a registered winrnd pulse.
// Button rising edge sampled at edge k yields winrnd after edge k+3; freezes in OVER on a win score.
module round_ctrl #(
  parameter int          MIN_DELAY   = 1000,
  parameter int          RAND_BITS   = 10,
  parameter int          LIT_TIMEOUT = 4000,
  parameter int          FTL_WINDOW  = 50,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_l,
  input  logic       pb_r,
  input  logic [6:0] score,
  output logic       leds_on,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       FTL_Left,
  output logic       FTL_Right
);
  import tow_pkg::*;

  localparam int DELAY_MAX = MIN_DELAY + (1 << RAND_BITS) - 1;
  localparam int CNT_MAX   = (DELAY_MAX > LIT_TIMEOUT) ? DELAY_MAX : LIT_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MIN     = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0] CNT_FTL     = CNT_W'(FTL_WINDOW);
  localparam logic [CNT_W-1:0] CNT_LIT_END = CNT_W'(LIT_TIMEOUT - 1);

  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:RAND_BITS];

  // Button vectors: bit 1 = left, bit 0 = right
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] dly_q, dly_d;
  logic [1:0] ep;
  logic       ep_l, ep_r, game_over, fast;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             leds_q, leds_d, winrnd_q, winrnd_d;
  logic             right_q, right_d, tie_q, tie_d;
  logic             ftl_l_q, ftl_l_d, ftl_r_q, ftl_r_d;

  assign ep        = sync_q & ~dly_q;
  assign ep_l      = ep[1];
  assign ep_r      = ep[0];
  assign fast      = cnt_q < CNT_FTL;
  assign game_over = (score != SCORE_RST) && ((score == SCORE_WL) || (score == SCORE_WR));

  always_comb begin
    meta_d   = {pb_l, pb_r};
    sync_d   = meta_q;
    dly_d    = sync_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    leds_d   = leds_q;
    winrnd_d = 1'b0;
    right_d  = right_q;
    tie_d    = tie_q;
    ftl_l_d  = ftl_l_q;
    ftl_r_d  = ftl_r_q;
    case (state_q)
      RELEASE: begin
        leds_d  = 1'b0;
        right_d = 1'b0;
        tie_d   = 1'b0;
        ftl_l_d = 1'b0;
        ftl_r_d = 1'b0;
        if (game_over) begin
          state_d = OVER;
        end else if (sync_q == 2'b00) begin
          cnt_d   = CNT_MIN + CNT_W'(lfsr_q[RAND_BITS-1:0]);
          state_d = DARK;
        end
      end
      DARK: begin
        // an edge wins over the expiring count: a push on the lighting cycle is still early
        if (ep_l || ep_r) begin
          state_d = SCORE;
          right_d = ep_r && !ep_l;
          tie_d   = ep_l && ep_r;
        end else if (cnt_q == '0) begin
          state_d = LIT;
          leds_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LIT: begin
        if (ep_l || ep_r) begin
          state_d = SCORE;
          right_d = ep_r && !ep_l;
          tie_d   = ep_l && ep_r;
          ftl_l_d = fast && ep_l && !ep_r;
          ftl_r_d = fast && ep_r && !ep_l;
        end else if (cnt_q == CNT_LIT_END) begin
          state_d = RELEASE;
          leds_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCORE: begin
        winrnd_d = 1'b1;
        state_d  = RELEASE;
      end
      OVER: begin
        leds_d  = 1'b0;
        right_d = 1'b0;
        tie_d   = 1'b0;
        ftl_l_d = 1'b0;
        ftl_r_d = 1'b0;
      end
      default: state_d = RELEASE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 2'b00;
      sync_q   <= 2'b00;
      dly_q    <= 2'b00;
      state_q  <= RELEASE;
      cnt_q    <= '0;
      leds_q   <= 1'b0;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      tie_q    <= 1'b0;
      ftl_l_q  <= 1'b0;
      ftl_r_q  <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      dly_q    <= dly_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      leds_q   <= leds_d;
      winrnd_q <= winrnd_d;
      right_q  <= right_d;
      tie_q    <= tie_d;
      ftl_l_q  <= ftl_l_d;
      ftl_r_q  <= ftl_r_d;
    end
  end

  assign leds_on   = leds_q;
  assign winrnd    = winrnd_q;
  assign right     = right_q;
  assign tie       = tie_q;
  assign FTL_Left  = ftl_l_q;
  assign FTL_Right = ftl_r_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with short delays; output vector order is {leds_on, winrnd, right, tie, FTL_Left, FTL_Right}.
module tb_round_ctrl;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       pb_l  = 1'b0;
  logic       pb_r  = 1'b0;
  logic [6:0] score = 7'b0001000;
  logic       leds_on, winrnd, right, tie, FTL_Left, FTL_Right;

  int n_chk  = 0;
  int n_pass = 0;
  int wins, lits;

  round_ctrl #(
    .MIN_DELAY   (8),
    .RAND_BITS   (2),
    .LIT_TIMEOUT (20),
    .FTL_WINDOW  (4),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_l      (pb_l),
    .pb_r      (pb_r),
    .score     (score),
    .leds_on   (leds_on),
    .winrnd    (winrnd),
    .right     (right),
    .tie       (tie),
    .FTL_Left  (FTL_Left),
    .FTL_Right (FTL_Right)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {leds_on, winrnd, right, tie, FTL_Left, FTL_Right};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic watch(input int n, output int w, output int l);
    w = 0;
    l = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (winrnd)  w++;
      if (leds_on) l++;
    end
  endtask

  // Returns one edge after leds_on is first seen high (edge L of the round)
  task automatic wait_leds(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (leds_on) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Call right after driving the button: pulse appears after the 4th edge, clears after the 5th
  task automatic check_round(input string tag, input logic [5:0] exp);
    ticks(3);
    check({tag, "_early"}, 32'(winrnd), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(outs()), 32'(exp));
    tick();
    check({tag, "_clear"}, 32'(outs()), 32'd0);
  endtask

  initial begin
    ticks(2);
    check("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // jump the light during DARK
    ticks(3);
    pb_r = 1'b1;
    check_round("jump", 6'b011000);
    watch(20, wins, lits);
    check("jump_held_wins", 32'(wins), 32'd0);
    check("jump_held_dark", 32'(lits), 32'd0);
    pb_r = 1'b0;

    // valid right push, push evaluated at cnt 7
    wait_leds("valid_lit");
    ticks(5);
    pb_r = 1'b1;
    check_round("valid_r", 6'b111000);
    pb_r = 1'b0;

    // fast left push at cnt 2, then held
    wait_leds("fast_lit");
    pb_l = 1'b1;
    check_round("fast_l", 6'b110010);
    watch(30, wins, lits);
    check("fast_held_wins", 32'(wins), 32'd0);
    check("fast_held_lits", 32'(lits), 32'd0);
    pb_l = 1'b0;

    // FTL boundary: cnt 3 is fast, cnt 4 is not
    wait_leds("ftl3_lit");
    ticks(1);
    pb_r = 1'b1;
    check_round("ftl_cnt3", 6'b111001);
    pb_r = 1'b0;
    wait_leds("ftl4_lit");
    ticks(2);
    pb_r = 1'b1;
    check_round("ftl_cnt4", 6'b111000);
    pb_r = 1'b0;

    // tie while lit, within FTL window: flags still clear
    wait_leds("tie_lit");
    pb_l = 1'b1;
    pb_r = 1'b1;
    check_round("tie", 6'b110100);
    pb_l = 1'b0;
    pb_r = 1'b0;

    // timeout: lit for 19 observed edges, off on the 20th, no pulse
    wait_leds("to_lit");
    watch(19, wins, lits);
    check("to_lit_span", 32'(lits), 32'd19);
    tick();
    check("to_fall", 32'(outs()), 32'd0);
    check("to_no_win", 32'(wins), 32'd0);
    wait_leds("to_next_round");

    // reset mid-LIT with a push already past the synchroniser
    pb_l = 1'b1;
    ticks(2);
    #2 rst = 1'b1;
    #1 check("rst_mid_lit", 32'(outs()), 32'd0);
    watch(3, wins, lits);
    check("rst_no_win", 32'(wins), 32'd0);
    pb_l = 1'b0;

    // game over on right-win pattern: pushes ignored, stays frozen after score changes
    score = 7'b0000111;
    rst   = 1'b0;
    wins  = 0;
    lits  = 0;
    for (int i = 0; i < 40; i++) begin
      pb_l = (i % 10) inside {[2:4]};
      pb_r = (i % 10) inside {[6:8]};
      tick();
      if (winrnd)  wins++;
      if (leds_on) lits++;
    end
    pb_l = 1'b0;
    pb_r = 1'b0;
    check("over_wins", 32'(wins), 32'd0);
    check("over_lits", 32'(lits), 32'd0);
    check("over_outs", 32'(outs()), 32'd0);
    score = 7'b0001000;
    watch(30, wins, lits);
    check("over_sticky", 32'(lits), 32'd0);

    // scorer reset pattern is not a win
    score = 7'b1100011;
    rst   = 1'b1;
    ticks(2);
    rst = 1'b0;
    wait_leds("rst_pattern_plays");

    // left-win pattern ends play at the next RELEASE
    score = 7'b1110000;
    watch(25, wins, lits);
    watch(30, wins, lits);
    check("over_wl_lits", 32'(lits), 32'd0);
    check("over_wl_wins", 32'(wins), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Generates the per-round stimulus consumed by the scorer: `leds_on`, `winrnd`, `right`, `tie`, `FTL_Left`, `FTL_Right`.
- Synchronises the two player pushbuttons and lights the LEDs after a pseudo-random delay.
- Arbitrates the first push, or a jump-the-light push, into one registered `winrnd` pulse.
- Watches the scorer's 7-bit score and freezes once a win pattern appears.

Parameters:
- MIN_DELAY, 1000: minimum cycles with LEDs off before lighting.
- RAND_BITS, 10: number of LFSR low bits added to MIN_DELAY; range 1..15.
- LIT_TIMEOUT, 4000: cycles LEDs stay lit with no push before the round aborts.
- FTL_WINDOW, 50: a valid push within this many cycles of lighting raises the FTL flag.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pb_l  in  1  left pushbutton, asynchronous, active-high
- pb_r  in  1  right pushbutton, asynchronous, active-high
- score  in  7  scorer output (L3 L2 L1 N R1 R2 R3)
- leds_on  out  1  round lights; stable through the winrnd cycle
- winrnd  out  1  one-cycle pulse: a push was resolved
- right  out  1  valid with winrnd; 1 means the right player pushed first
- tie  out  1  valid with winrnd; both players pushed in the same cycle
- FTL_Left  out  1  valid with winrnd; left made a fast valid push
- FTL_Right  out  1  valid with winrnd; right made a fast valid push

Behaviour:
- Reset values: all outputs 0. State RELEASE, counter 0, LFSR = LFSR_SEED, synchronisers 0.
- Inputs: each button passes through a 2-flop synchroniser (pl_s, pr_s), then a rising-edge detect against a delayed copy.
- Push edge: `ep = pX_s & ~pX_d`.
- Latency: raw button high at edge k gives `winrnd` high after edge k+3, for exactly 1 cycle.
- All outputs are registered.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle regardless of state.
- States:
  - RELEASE:
    - waits until pl_s=0 and pr_s=0, then loads `cnt = MIN_DELAY + lfsr[RAND_BITS-1:0]`.
    - Next state DARK.
  - DARK:
    - `leds_on=0`; cnt decrements.
    - Any edge here is a jump-the-light → SCORE with `leds_on` held 0 and `right = (edge on r)`.
    - Both edges in the same cycle → `tie=1`, `right=0`.
    - cnt==0 with no edge → LIT, `leds_on=1`, cnt=0 counting up.
  - LIT:
    - `leds_on=1`; cnt increments.
    - First edge → SCORE with `right` and `tie` resolved as in DARK.
    - `FTL_X=1` when cnt < FTL_WINDOW for the pushing side; both FTL flags 0 on a tie.
    - cnt == LIT_TIMEOUT-1 with no edge → `leds_on=0`, RELEASE, no `winrnd`.
  - SCORE:
    - `winrnd=1` for one cycle; `leds_on`, `right`, `tie`, `FTL_*` hold their registered values.
    - Next cycle: all pulse-qualified outputs clear, `leds_on=0`, state RELEASE.
  - OVER:
    - entered from RELEASE when score == 7'b1110000 or 7'b0000111.
    - All outputs 0; buttons ignored until rst.
- Edge arriving in the same cycle as the DARK→LIT transition: counts as jump-the-light (`leds_on=0`).
- Buttons held through RELEASE produce no edges; a held button never scores twice.
- score 7'b1100011 (scorer reset pattern) is treated as not-over.
- rst mid-round: immediate return to reset values; no `winrnd` is emitted.

Decomposition:
- Package `tow_pkg`:
  - state enum: RELEASE, DARK, LIT, SCORE, OVER
  - constants SCORE_WL=7'b1110000, SCORE_WR=7'b0000111, SCORE_RST=7'b1100011
  - LFSR tap mask
- Sub-module `lfsr16` (clk, rst, seed parameter, q[15:0]); used for the delay draw.
- Synchronisers and edge detects stay inline.

Test Plan (MIN_DELAY=8, RAND_BITS=2, LIT_TIMEOUT=20, FTL_WINDOW=4, score=7'b0001000):
- Valid right push: after `leds_on` rises, raise pb_r 6 cycles later → after 3 edges `winrnd`=1 for 1 cycle with `right`=1, `leds_on`=1, `tie`=0, `FTL_Right`=0.
- Fast left push: pb_l 1 cycle after `leds_on` rises → `winrnd`=1, `right`=0, `FTL_Left`=1; no second pulse while pb_l stays held.
- Jump the light: pb_r during DARK, 3 cycles after reset release → `winrnd`=1, `leds_on`=0, `right`=1; DARK restarts only after pb_r is released.
- Tie: pb_l and pb_r rise on the same edge while lit → `winrnd`=1, `tie`=1, `right`=0, `FTL_Left`=`FTL_Right`=0.
- Timeout: no push while lit → `leds_on` falls 20 cycles after rising with no `winrnd`; a new DARK period follows.
- Game over and reset: drive score=7'b0000111 → state OVER, outputs 0, pushes ignored; assert rst mid-LIT → `leds_on`=0 immediately, no `winrnd`.
